// File: rtl/text_pkg.sv
// ---------------------------------------------------------------------------
// text_pkg
// Shared constants and types for the text console writer.
//   COLS, ROWS, CELLS : default screen geometry (80 x 25 = 2000 cells)
//   CH_*              : control codes recognised by the console
//   state_t           : console FSM states
//   clear_byte()      : blank-cell byte for a given RAM byte address
// ---------------------------------------------------------------------------
package text_pkg;

    localparam int COLS  = 80;
    localparam int ROWS  = 25;
    localparam int CELLS = COLS * ROWS;

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PUT_C     = 3'd1,
        PUT_A     = 3'd2,
        SCROLL_RD = 3'd3,
        SCROLL_WR = 3'd4,
        CLEAR     = 3'd5
    } state_t;

    // A blank cell is a space character followed by the current attribute.
    function automatic logic [7:0] clear_byte(input logic [11:0] addr,
                                              input logic [7:0]  attr);
        return addr[0] ? attr : CH_SPACE;
    endfunction

endpackage

// File: rtl/text_console.sv
// ---------------------------------------------------------------------------
// text_console
// Interprets a byte stream (characters and control codes) and maintains a
// character/attribute text screen in an external byte-wide RAM.
//
// Ports
//   clock        system clock, all state changes on its rising edge
//   reset        synchronous, active-high; starts a full-screen clear
//   in_valid     in_data holds a byte to process
//   in_data      character / control code, or new attribute when attr_set=1
//   attr_set     current transfer loads the attribute register
//   in_ready     console can accept a transfer this cycle (IDLE only)
//   mem_address  RAM byte address; cell n: char at 2n, attr at 2n+1
//   mem_wdata    RAM write data
//   mem_we       RAM write strobe, one byte per cycle
//   mem_rdata    RAM read data, valid one cycle after mem_address
//   cursor       current cell index, 0..CELLS-1
//   fsm_state    current FSM state (debug visibility)
//
// Handshake: a byte is transferred on a rising edge where in_valid and
// in_ready are both high. in_ready is high only in IDLE; the producer must
// hold in_valid/in_data/attr_set stable until that edge.
// ---------------------------------------------------------------------------
module text_console #(
    parameter logic [7:0] DEFAULT_ATTR = 8'h07,
    parameter int         COLS         = text_pkg::COLS,
    parameter int         ROWS         = text_pkg::ROWS
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        attr_set,
    output logic        in_ready,
    output logic [11:0] mem_address,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata,
    output logic [10:0] cursor,
    output logic [2:0]  fsm_state
);
    import text_pkg::*;

    localparam int          N_CELLS      = COLS * ROWS;
    localparam logic [10:0] COLS_C       = 11'(COLS);
    localparam logic [10:0] CELLS_C      = 11'(N_CELLS);
    localparam logic [10:0] LAST_ROW_C   = 11'(N_CELLS - COLS);
    localparam logic [11:0] LF_LIMIT     = 12'(N_CELLS);
    localparam logic [11:0] ROW_BYTES    = 12'(2 * COLS);
    localparam logic [11:0] MOVE_BYTES   = 12'(2 * (N_CELLS - COLS));
    localparam logic [11:0] SCREEN_BYTES = 12'(2 * N_CELLS);

    state_t      state;
    logic [11:0] count;         // byte counter shared by scroll and clear
    logic [7:0]  attr;
    logic [7:0]  wdata_q;
    logic        advance;       // PUT_C/PUT_A pair moves the cursor on
    logic        scroll_after;  // cursor ran off the screen: scroll after PUT_A

    logic [10:0] col;
    logic [10:0] cursor_next;
    logic [10:0] cursor_back;
    logic [11:0] cursor_down;   // one bit wider: cursor + COLS may pass 2047

    assign col         = cursor % COLS_C;
    assign cursor_next = cursor + 11'd1;
    assign cursor_back = cursor - 11'd1;
    assign cursor_down = {1'b0, cursor} + {1'b0, COLS_C};

    // During SCROLL_WR the byte read in the preceding SCROLL_RD cycle is on
    // mem_rdata and goes straight back out to the lower address.
    assign mem_wdata = (state == SCROLL_WR) ? mem_rdata : wdata_q;
    assign fsm_state = state;

    always_ff @(posedge clock) begin
        if (reset) begin
            // Enter CLEAR with no byte presented yet; the first clear write
            // appears one cycle after reset is released.
            state        <= CLEAR;
            count        <= 12'd0;
            cursor       <= 11'd0;
            attr         <= DEFAULT_ATTR;
            wdata_q      <= 8'd0;
            mem_address  <= 12'd0;
            mem_we       <= 1'b0;
            in_ready     <= 1'b0;
            advance      <= 1'b0;
            scroll_after <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        if (attr_set) begin
                            attr <= in_data;
                        end else if (in_data >= CH_SPACE) begin
                            state       <= PUT_C;
                            mem_address <= {cursor, 1'b0};
                            wdata_q     <= in_data;
                            mem_we      <= 1'b1;
                            in_ready    <= 1'b0;
                            advance     <= 1'b1;
                        end else begin
                            case (in_data)
                                CH_CR: cursor <= cursor - col;
                                CH_LF: begin
                                    if (cursor_down >= LF_LIMIT) begin
                                        // Bottom row: scroll, cursor stays put.
                                        state       <= SCROLL_RD;
                                        count       <= 12'd0;
                                        mem_address <= ROW_BYTES;
                                        in_ready    <= 1'b0;
                                    end else begin
                                        cursor <= cursor_down[10:0];
                                    end
                                end
                                CH_BS: begin
                                    if (col != 11'd0) begin
                                        cursor      <= cursor_back;
                                        state       <= PUT_C;
                                        mem_address <= {cursor_back, 1'b0};
                                        wdata_q     <= CH_SPACE;
                                        mem_we      <= 1'b1;
                                        in_ready    <= 1'b0;
                                        advance     <= 1'b0;
                                    end
                                end
                                CH_FF: begin
                                    // Byte 0 is presented right away.
                                    cursor      <= 11'd0;
                                    state       <= CLEAR;
                                    count       <= 12'd1;
                                    mem_address <= 12'd0;
                                    wdata_q     <= clear_byte(12'd0, attr);
                                    mem_we      <= 1'b1;
                                    in_ready    <= 1'b0;
                                end
                                default: ;
                            endcase
                        end
                    end
                end

                PUT_C: begin
                    state        <= PUT_A;
                    mem_address  <= {cursor, 1'b1};
                    wdata_q      <= attr;
                    mem_we       <= 1'b1;
                    scroll_after <= 1'b0;
                    if (advance) begin
                        if (cursor_next == CELLS_C) begin
                            cursor       <= LAST_ROW_C;
                            scroll_after <= 1'b1;
                        end else begin
                            cursor <= cursor_next;
                        end
                    end
                end

                PUT_A: begin
                    mem_we <= 1'b0;
                    if (scroll_after) begin
                        state       <= SCROLL_RD;
                        count       <= 12'd0;
                        mem_address <= ROW_BYTES;
                    end else begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                    end
                end

                SCROLL_RD: begin
                    state       <= SCROLL_WR;
                    mem_address <= count;
                    mem_we      <= 1'b1;
                end

                SCROLL_WR: begin
                    if (count == MOVE_BYTES - 12'd1) begin
                        // Rows moved up; blank the last row through CLEAR.
                        state       <= CLEAR;
                        mem_address <= MOVE_BYTES;
                        wdata_q     <= clear_byte(MOVE_BYTES, attr);
                        count       <= MOVE_BYTES + 12'd1;
                    end else begin
                        state       <= SCROLL_RD;
                        mem_address <= count + 12'd1 + ROW_BYTES;
                        mem_we      <= 1'b0;
                        count       <= count + 12'd1;
                    end
                end

                CLEAR: begin
                    if (count == SCREEN_BYTES) begin
                        state    <= IDLE;
                        mem_we   <= 1'b0;
                        in_ready <= 1'b1;
                    end else begin
                        mem_address <= count;
                        wdata_q     <= clear_byte(count, attr);
                        mem_we      <= 1'b1;
                        count       <= count + 12'd1;
                    end
                end

                default: begin
                    state    <= IDLE;
                    mem_we   <= 1'b0;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_text_console.sv
// ---------------------------------------------------------------------------
// tb_text_console
// Bench for text_console: a byte-wide RAM with one-cycle read latency, a
// screen model (character and attribute per cell, cursor, attribute) and
// scenario tasks comparing the RAM contents and cursor against the model.
// ---------------------------------------------------------------------------
module tb_text_console;

    localparam int COLS  = 80;
    localparam int ROWS  = 25;
    localparam int CELLS = COLS * ROWS;
    localparam int BYTES = 2 * CELLS;

    // ---------------- clock / reset ----------------
    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        attr_set;
    logic        in_ready;
    logic [11:0] mem_address;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;
    logic [10:0] cursor;
    logic [2:0]  fsm_state;

    always #5 clock = ~clock;

    text_console dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .attr_set    (attr_set),
        .in_ready    (in_ready),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_rdata   (mem_rdata),
        .cursor      (cursor),
        .fsm_state   (fsm_state)
    );

    // ---------------- text RAM and bus monitors ----------------
    logic [7:0] ram [BYTES];
    int wr_count   = 0;
    int bad_addr   = 0;
    int we_in_idle = 0;

    always @(posedge clock) begin
        if (mem_we) begin
            wr_count <= wr_count + 1;
            if (mem_address < 12'(BYTES)) ram[mem_address] <= mem_wdata;
            else bad_addr <= bad_addr + 1;
            if (in_ready) we_in_idle <= we_in_idle + 1;
        end
        mem_rdata <= ram[mem_address];
    end

    // ---------------- screen model / scoreboard ----------------
    logic [7:0] m_ch [CELLS];
    logic [7:0] m_at [CELLS];
    int         m_cur;
    logic [7:0] m_attr;
    logic [7:0] exp_q [$];

    int checks   = 0;
    int errors   = 0;
    int timeouts = 0;

    function automatic void m_clear();
        for (int n = 0; n < CELLS; n++) begin
            m_ch[n] = 8'h20;
            m_at[n] = m_attr;
        end
        m_cur = 0;
    endfunction

    function automatic void m_scroll();
        for (int n = 0; n < CELLS - COLS; n++) begin
            m_ch[n] = m_ch[n + COLS];
            m_at[n] = m_at[n + COLS];
        end
        for (int n = CELLS - COLS; n < CELLS; n++) begin
            m_ch[n] = 8'h20;
            m_at[n] = m_attr;
        end
    endfunction

    function automatic void model_byte(input logic [7:0] b, input logic aset);
        if (aset) begin
            m_attr = b;
        end else if (b >= 8'h20) begin
            m_ch[m_cur] = b;
            m_at[m_cur] = m_attr;
            m_cur++;
            if (m_cur == CELLS) begin
                m_scroll();
                m_cur = CELLS - COLS;
            end
        end else if (b == 8'h0D) begin
            m_cur = m_cur - (m_cur % COLS);
        end else if (b == 8'h0A) begin
            if (m_cur + COLS >= CELLS) m_scroll();
            else m_cur = m_cur + COLS;
        end else if (b == 8'h08) begin
            if (m_cur % COLS != 0) begin
                m_cur--;
                m_ch[m_cur] = 8'h20;
                m_at[m_cur] = m_attr;
            end
        end else if (b == 8'h0C) begin
            m_clear();
        end
    endfunction

    function automatic logic [7:0] exp_byte(input int a);
        return (a % 2 == 0) ? m_ch[a / 2] : m_at[a / 2];
    endfunction

    // Compares whole RAM image with the model; returns count and first index.
    task automatic screen_diffs(output int bad, output int first);
        logic [7:0] e;
        exp_q.delete();
        for (int n = 0; n < CELLS; n++) begin
            exp_q.push_back(m_ch[n]);
            exp_q.push_back(m_at[n]);
        end
        bad   = 0;
        first = 0;
        for (int a = 0; a < BYTES; a++) begin
            e = exp_q.pop_front();
            if (ram[a] !== e) begin
                if (bad == 0) first = a;
                bad++;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_ready(input int budget, input string name, output int cycles);
        cycles = 0;
        while (in_ready !== 1'b1 && cycles < budget) begin
            @(negedge clock);
            cycles++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            timeouts++;
            $display("FAIL %s timeout: in_ready=%b after %0d cycles, required 1", name, in_ready, cycles);
            if (timeouts >= 3) begin
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
    endtask

    task automatic send(input logic [7:0] b, input logic aset);
        int c;
        wait_ready(20000, "send", c);
        in_valid = 1'b1;
        in_data  = b;
        attr_set = aset;
        @(negedge clock);
        in_valid = 1'b0;
        attr_set = 1'b0;
        model_byte(b, aset);
    endtask

    function automatic logic [7:0] pattern(input int i);
        return 8'h21 + 8'((i * 7) % 90);
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int c, w0, bad, first;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if (mem_we !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: mem_we=%b in_ready=%b, required 0 0", mem_we, in_ready);
        end
        checks++;
        if (cursor !== 11'd0) begin
            errors++;
            $display("FAIL reset_cursor: got %0d, required 0", cursor);
        end
        w0 = wr_count;
        reset = 1'b0;
        m_attr = 8'h07;
        m_clear();
        wait_ready(6000, "reset_clear", c);
        checks++;
        if (c !== 4001) begin
            errors++;
            $display("FAIL reset_ready_latency: got %0d cycles, required 4001", c);
        end
        checks++;
        if (wr_count - w0 !== 4000) begin
            errors++;
            $display("FAIL reset_write_count: got %0d, required 4000", wr_count - w0);
        end
        screen_diffs(bad, first);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL reset_screen: %0d bytes differ, byte %0d is %h, required %h", bad, first, ram[first], exp_byte(first));
        end
        checks++;
        if (cursor !== 11'd0) begin
            errors++;
            $display("FAIL reset_cursor_after_clear: got %0d, required 0", cursor);
        end
    endtask

    task automatic test_char();
        int c;
        send(8'h41, 1'b0);
        checks++;
        if (in_ready !== 1'b0 || mem_we !== 1'b1 || mem_address !== 12'd0 || mem_wdata !== 8'h41) begin
            errors++;
            $display("FAIL char_put_c: ready=%b we=%b addr=%0d data=%h, required 0 1 0 41", in_ready, mem_we, mem_address, mem_wdata);
        end
        wait_ready(50, "char_ready", c);
        checks++;
        if (c !== 2) begin
            errors++;
            $display("FAIL char_ready_latency: got %0d further cycles, required 2", c);
        end
        checks++;
        if (ram[0] !== 8'h41 || ram[1] !== 8'h07) begin
            errors++;
            $display("FAIL char_mem: mem[0]=%h mem[1]=%h, required 41 07", ram[0], ram[1]);
        end
        checks++;
        if (cursor !== 11'd1) begin
            errors++;
            $display("FAIL char_cursor: got %0d, required 1", cursor);
        end
    endtask

    task automatic test_attr_crlf();
        int c, w0, bad, first;
        for (int i = 0; i < 78; i++) send(8'($urandom_range(32, 126)), 1'b0);
        wait_ready(50, "fill_ready", c);
        checks++;
        if (cursor !== 11'd79) begin
            errors++;
            $display("FAIL fill_cursor: got %0d, required 79", cursor);
        end
        w0 = wr_count;
        send(8'h1E, 1'b1);
        wait_ready(50, "attr_ready", c);
        checks++;
        if (c !== 0 || wr_count - w0 !== 0) begin
            errors++;
            $display("FAIL attr_set: wait=%0d writes=%0d, required 0 0", c, wr_count - w0);
        end
        send(8'h42, 1'b0);
        wait_ready(50, "b_ready", c);
        checks++;
        if (ram[158] !== 8'h42 || ram[159] !== 8'h1E || cursor !== 11'd80) begin
            errors++;
            $display("FAIL b_cell: mem[158]=%h mem[159]=%h cursor=%0d, required 42 1e 80", ram[158], ram[159], cursor);
        end
        w0 = wr_count;
        send(8'h0D, 1'b0);
        wait_ready(50, "cr_ready", c);
        checks++;
        if (cursor !== 11'd80 || wr_count - w0 !== 0) begin
            errors++;
            $display("FAIL cr: cursor=%0d writes=%0d, required 80 0", cursor, wr_count - w0);
        end
        send(8'h0A, 1'b0);
        wait_ready(50, "lf_ready", c);
        checks++;
        if (cursor !== 11'd160 || wr_count - w0 !== 0) begin
            errors++;
            $display("FAIL lf: cursor=%0d writes=%0d, required 160 0", cursor, wr_count - w0);
        end
        screen_diffs(bad, first);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL crlf_screen: %0d bytes differ, byte %0d is %h, required %h", bad, first, ram[first], exp_byte(first));
        end
    endtask

    task automatic test_backspace();
        int c, w0, bad, first;
        w0 = wr_count;
        send(8'h0C, 1'b0);
        wait_ready(5000, "ff_ready", c);
        checks++;
        if (c !== 4000 || wr_count - w0 !== 4000 || cursor !== 11'd0) begin
            errors++;
            $display("FAIL form_feed: cycles=%0d writes=%0d cursor=%0d, required 4000 4000 0", c, wr_count - w0, cursor);
        end
        w0 = wr_count;
        send(8'h08, 1'b0);
        wait_ready(50, "bs0_ready", c);
        checks++;
        if (cursor !== 11'd0 || wr_count - w0 !== 0) begin
            errors++;
            $display("FAIL bs_col0: cursor=%0d writes=%0d, required 0 0", cursor, wr_count - w0);
        end
        for (int i = 0; i < 5; i++) send(8'($urandom_range(33, 126)), 1'b0);
        send(8'h08, 1'b0);
        wait_ready(50, "bs_ready", c);
        checks++;
        if (cursor !== 11'd4 || ram[8] !== 8'h20 || ram[9] !== m_attr) begin
            errors++;
            $display("FAIL bs: cursor=%0d mem[8]=%h mem[9]=%h, required 4 20 %h", cursor, ram[8], ram[9], m_attr);
        end
        screen_diffs(bad, first);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL bs_screen: %0d bytes differ, byte %0d is %h, required %h", bad, first, ram[first], exp_byte(first));
        end
    endtask

    task automatic test_scroll();
        int c, w0, bad, first;
        send(8'h0C, 1'b0);
        for (int i = 0; i < CELLS - 1; i++) send(pattern(i), 1'b0);
        wait_ready(50, "pattern_ready", c);
        checks++;
        if (cursor !== 11'd1999) begin
            errors++;
            $display("FAIL pattern_cursor: got %0d, required 1999", cursor);
        end
        w0 = wr_count;
        send(8'h5A, 1'b0);
        // 2 put cycles, 3840 read/write pairs, 160 blanking writes, then ready.
        wait_ready(9000, "scroll_ready", c);
        checks++;
        if (c !== 7842 || wr_count - w0 !== 4002) begin
            errors++;
            $display("FAIL scroll_timing: cycles=%0d writes=%0d, required 7842 4002", c, wr_count - w0);
        end
        checks++;
        if (cursor !== 11'd1920) begin
            errors++;
            $display("FAIL scroll_cursor: got %0d, required 1920", cursor);
        end
        checks++;
        if (ram[0] !== pattern(80) || ram[3838] !== 8'h5A || ram[3998] !== 8'h20 || ram[3999] !== m_attr) begin
            errors++;
            $display("FAIL scroll_cells: mem[0]=%h mem[3838]=%h mem[3998]=%h mem[3999]=%h, required %h 5a 20 %h",
                     ram[0], ram[3838], ram[3998], ram[3999], pattern(80), m_attr);
        end
        screen_diffs(bad, first);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL scroll_screen: %0d bytes differ, byte %0d is %h, required %h", bad, first, ram[first], exp_byte(first));
        end
    endtask

    task automatic test_random();
        int c, r, bad, first;
        logic [7:0] b;
        for (int i = 0; i < 120; i++) begin
            r = $urandom_range(0, 99);
            if (r < 68) begin
                send(8'($urandom_range(32, 255)), 1'b0);
            end else if (r < 76) begin
                send(8'($urandom_range(0, 255)), 1'b1);
            end else if (r < 84) begin
                send(8'h0D, 1'b0);
            end else if (r < 90) begin
                send(8'h08, 1'b0);
            end else if (r < 97) begin
                do b = 8'($urandom_range(0, 31));
                while (b == 8'h08 || b == 8'h0A || b == 8'h0C || b == 8'h0D);
                send(b, 1'b0);
            end else begin
                send(8'h0A, 1'b0);
            end
            wait_ready(20000, "rand_ready", c);
            checks++;
            if (cursor !== 11'(m_cur)) begin
                errors++;
                $display("FAIL rand_cursor op %0d: got %0d, required %0d", i, cursor, m_cur);
            end
        end
        screen_diffs(bad, first);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL rand_screen: %0d bytes differ, byte %0d is %h, required %h", bad, first, ram[first], exp_byte(first));
        end
    endtask

    task automatic test_reset_mid_scroll();
        int c, w0, bad, first;
        send(8'h0D, 1'b0);
        while (m_cur + COLS < CELLS) send(8'h0A, 1'b0);
        send(8'h0A, 1'b0);
        repeat (1000) @(negedge clock);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_scroll_busy: in_ready=%b, required 0", in_ready);
        end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (mem_we !== 1'b0 || in_ready !== 1'b0 || cursor !== 11'd0) begin
            errors++;
            $display("FAIL mid_scroll_reset: mem_we=%b in_ready=%b cursor=%0d, required 0 0 0", mem_we, in_ready, cursor);
        end
        w0 = wr_count;
        reset = 1'b0;
        m_attr = 8'h07;
        m_clear();
        wait_ready(6000, "reclear_ready", c);
        checks++;
        if (c !== 4001 || wr_count - w0 !== 4000) begin
            errors++;
            $display("FAIL reclear: cycles=%0d writes=%0d, required 4001 4000", c, wr_count - w0);
        end
        screen_diffs(bad, first);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL reclear_screen: %0d bytes differ, byte %0d is %h, required %h", bad, first, ram[first], exp_byte(first));
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        attr_set = 1'b0;
        test_reset();
        test_char();
        test_attr_crlf();
        test_backspace();
        test_scroll();
        test_random();
        test_reset_mid_scroll();
        checks++;
        if (bad_addr !== 0) begin
            errors++;
            $display("FAIL address_range: %0d writes beyond byte 3999, required 0", bad_addr);
        end
        checks++;
        if (we_in_idle !== 0) begin
            errors++;
            $display("FAIL write_while_ready: %0d writes with in_ready high, required 0", we_in_idle);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
